avalon_reg_slave: RTL
=====================

// Module: avalon_reg_slave
// PURPOSE
//  Parametrised Avalon-MM slave register bank for UART-lab DUTs and benches. Decodes word addresses
//  into NB_REGS registers, applies byte-enabled writes and returns pipelined reads with
//  readdatavalid_o after a fixed READ_LATENCY. Exports register contents and per-register write
//  strobes to user logic. Read-only registers return the live status_i word.
// PARAMETERS
//  ADDR_WIDTH    14           word-address width
//  DATA_WIDTH    32           data width; multiple of 8
//  NB_REGS       16           register count, 1..2**ADDR_WIDTH
//  READ_LATENCY  2            cycles from read acceptance to readdatavalid_o, 1..4
//  RO_MASK       '0           [NB_REGS] bit i=1: reg i is read-only (reads status_i slice i)
//  RESET_VALUE   '0           [DATA_WIDTH] reset content of every RW register
// PORTS
//  clk_i            in   1                      clock
//  rst_i            in   1                      synchronous reset, active-high
//  address_i        in   ADDR_WIDTH             word address
//  byteenable_i     in   DATA_WIDTH/8           write byte lanes
//  write_i          in   1                      write request
//  writedata_i      in   DATA_WIDTH             write data
//  read_i           in   1                      read request
//  readdatavalid_o  out  1                      readdata_o valid this cycle
//  readdata_o       out  DATA_WIDTH             read data
//  waitrequest_o    out  1                      slave stall
//  status_i         in   NB_REGS*DATA_WIDTH     live values for RO registers
//  reg_q_o          out  NB_REGS*DATA_WIDTH     current RW register contents (RO slices = 0)
//  reg_wr_o         out  NB_REGS                one-cycle strobe per accepted write
// BEHAVIOUR
//  - Reset (rst_i=1 at clk_i edge): RW regs=RESET_VALUE; readdatavalid_o=0; readdata_o=0;
//    reg_wr_o=0; waitrequest_o=1; read pipeline flushed; FSM->INIT.
//  - FSM states INIT, READY, STALL (STALL only with the macro). INIT->READY one cycle after rst_i
//    falls, so waitrequest_o stays 1 for exactly one cycle after reset release.
//  - Acceptance: request accepted on an edge where (read_i|write_i)=1 and waitrequest_o=0.
//  - Write: byte lane b of reg[address_i] <= writedata_i lane b iff byteenable_i[b]. RO regs and
//    address_i>=NB_REGS ignore data; reg_wr_o[idx] pulses the cycle after acceptance for any
//    in-range idx (RO included); out of range: no strobe.
//  - Read: data captured at acceptance (read-before-write); readdatavalid_o=1 and readdata_o
//    valid exactly READ_LATENCY cycles later. Fully pipelined: one read per cycle, responses in
//    order. Out-of-range read returns 0. readdata_o holds its last value when not valid.
//  - read_i & write_i together: protocol error; write performed, read dropped (no response).
//  - Reset mid-read: in-flight responses discarded, readdatavalid_o never pulses for them.
// CONFIGURATION
//  Macro AVALON_REG_WAITSTATE_EN:
//   defined: READY + new request -> STALL (waitrequest_o=1 one cycle) -> READY, request accepted
//    on the STALL->READY edge; back-to-back requests cost 2 cycles each. Request must stay stable
//    while stalled.
//   undefined: waitrequest_o = 1 only in reset and INIT; every other cycle accepts.
// STRUCTURE
//  Package avalon_reg_pkg: state_t enum {INIT, READY, STALL}; MAX_READ_LATENCY=4; function
//  byte_merge(old, new, be) returning the lane-merged word.
//  Sub-module avalon_rd_pipe: READ_LATENCY-deep valid/data shift register with sync flush.
// TESTING
//  1. Reset, release -> waitrequest_o=1 one cycle then 0; read reg 3 -> 0 after 2 cycles.
//  2. Write reg 5 = 0xA1B2C3D4 be=4'b0101 from 0 -> reg 5 reads 0x00B200D4; reg_wr_o[5] 1 cycle.
//  3. Reads regs 0,1,2,3 on consecutive cycles -> 4 consecutive readdatavalid_o, in order.
//  4. RO_MASK[7]=1, status 0x55; write 0xFF to reg 7 -> reads 0x55; read addr 20 -> 0.
//  5. Read reg 2 then rst_i=1 next cycle -> no readdatavalid_o; reg 2 back to RESET_VALUE.
//  6. Macro defined: 3 back-to-back writes -> waitrequest_o pattern 1,0,1,0,1,0; all applied.

Source files
------------

// File: rtl/avalon_reg_pkg.sv
// Shared types and helpers for the Avalon-MM register slave.
package avalon_reg_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        READY = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam int MAX_READ_LATENCY = 4;
    // byte_merge works on the widest supported word; callers zero-extend and truncate.
    localparam int MAX_DATA_WIDTH   = 256;
    localparam int MAX_BE_WIDTH     = MAX_DATA_WIDTH / 8;

    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_w,
        input logic [MAX_DATA_WIDTH-1:0] new_w,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_w;
        for (int b = 0; b < MAX_BE_WIDTH; b++) begin
            if (be[b]) merged[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/avalon_rd_pipe.sv
// Read response pipeline: DEPTH-stage valid/data shift register with synchronous flush.
module avalon_rd_pipe
    import avalon_reg_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o
);

    localparam int STAGES = (DEPTH > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                            ((DEPTH < 1) ? 1 : DEPTH);

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q,  data_d;

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        valid_d    = '0;
        data_d     = data_q;
        valid_d[0] = in_valid_i;
        if (in_valid_i) data_d[0] = in_data_i;
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) data_d[i] = data_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Stages only load on valid, so the last one holds the previous response between pulses.
    assign out_valid_o = valid_q[STAGES-1];
    assign out_data_o  = data_q[STAGES-1];

endmodule

// File: rtl/avalon_reg_slave.sv
// Avalon-MM register bank: byte-enabled writes, pipelined reads, write strobes, RO status regs.
// Define AVALON_REG_WAITSTATE_EN to insert one wait state before every accepted request.
module avalon_reg_slave
    import avalon_reg_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 14,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    NB_REGS      = 16,
    parameter int                    READ_LATENCY = 2,
    parameter logic [NB_REGS-1:0]    RO_MASK      = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [ADDR_WIDTH-1:0]         address_i,
    input  logic [DATA_WIDTH/8-1:0]       byteenable_i,
    input  logic                          write_i,
    input  logic [DATA_WIDTH-1:0]         writedata_i,
    input  logic                          read_i,
    output logic                          readdatavalid_o,
    output logic [DATA_WIDTH-1:0]         readdata_o,
    output logic                          waitrequest_o,
    input  logic [NB_REGS*DATA_WIDTH-1:0] status_i,
    output logic [NB_REGS*DATA_WIDTH-1:0] reg_q_o,
    output logic [NB_REGS-1:0]            reg_wr_o
);

    localparam int IDX_W = (NB_REGS > 1) ? $clog2(NB_REGS) : 1;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] NB_REGS_A = AW1'(NB_REGS);

    function automatic logic [NB_REGS-1:0][DATA_WIDTH-1:0] reset_image();
        logic [NB_REGS-1:0][DATA_WIDTH-1:0] img;
        for (int i = 0; i < NB_REGS; i++) img[i] = RO_MASK[i] ? '0 : RESET_VALUE;
        return img;
    endfunction

    localparam logic [NB_REGS-1:0][DATA_WIDTH-1:0] REGS_RESET = reset_image();

    state_t                             state_q, state_d;
    logic [NB_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NB_REGS-1:0]                 reg_wr_q, reg_wr_d;
    logic                               req, accept, wr_accept, rd_accept, in_range;
    logic [IDX_W-1:0]                   idx;
    logic [DATA_WIDTH-1:0]              rd_word;

    assign req = read_i | write_i;
`ifdef AVALON_REG_WAITSTATE_EN
    assign waitrequest_o = (state_q == INIT) || ((state_q == READY) && req);
`else
    assign waitrequest_o = (state_q != READY);
`endif
    assign accept    = req & ~waitrequest_o;
    assign wr_accept = accept & write_i;
    // A simultaneous read+write is a protocol error: the write wins and the read is dropped.
    assign rd_accept = accept & read_i & ~write_i;
    assign in_range  = {1'b0, address_i} < NB_REGS_A;
    assign idx       = address_i[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = READY;
            READY: begin
`ifdef AVALON_REG_WAITSTATE_EN
                if (req) state_d = STALL;
`endif
            end
            STALL:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        regs_d   = regs_q;
        reg_wr_d = '0;
        rd_word  = '0;
        for (int i = 0; i < NB_REGS; i++) begin
            if (in_range && (idx == IDX_W'(i))) begin
                rd_word = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
                if (wr_accept) begin
                    reg_wr_d[i] = 1'b1;
                    if (!RO_MASK[i]) begin
                        regs_d[i] = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(regs_q[i]),
                                                           MAX_DATA_WIDTH'(writedata_i),
                                                           MAX_BE_WIDTH'(byteenable_i)));
                    end
                end
            end
        end
    end

    // NOTE: the register array is reset because its contents are architecturally visible after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= INIT;
            reg_wr_q <= '0;
            regs_q   <= REGS_RESET;
        end else begin
            state_q  <= state_d;
            reg_wr_q <= reg_wr_d;
            regs_q   <= regs_d;
        end
    end

    // RO slots never leave their zero reset image, so the bank maps straight onto reg_q_o.
    assign reg_q_o  = regs_q;
    assign reg_wr_o = reg_wr_q;

    avalon_rd_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (rd_accept),
        .in_data_i   (rd_word),
        .out_valid_o (readdatavalid_o),
        .out_data_o  (readdata_o)
    );

endmodule
